// File: rtl/pll_sup_pkg.sv
// Shared definitions for the PLL lock supervisor: state encoding and
// default timing derived from the 50 MHz reference clock.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAILED    = 3'd4
  } pll_state_e;

  localparam int unsigned REFCLK_HZ               = 50_000_000;
  localparam int unsigned DEF_RST_PULSE_CYCLES    = 16;
  // 1 ms of refclk before an attempt is declared failed
  localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = REFCLK_HZ / 1000;
  localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int unsigned DEF_MAX_RETRIES         = 3;
  localparam int unsigned DEF_CNT_W               = 16;

  localparam logic [7:0]  LOSS_CNT_MAX            = 8'hFF;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser, reset value 0.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] s2_q;

  // Two back-to-back capture stages; only s2_q is used downstream
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses the PLL reset, waits for lock with a timeout
// and bounded retries, qualifies lock stability, then releases sys_rst.
// Losing lock in RUN restarts the whole sequence.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int unsigned RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int unsigned MAX_RETRIES         = DEF_MAX_RETRIES,
  parameter int unsigned CNT_W               = DEF_CNT_W
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retry_cnt,
  output logic [7:0] loss_cnt,
  output logic [2:0] state_o
);

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [3:0]       RETRY_MAX   = 4'(MAX_RETRIES);

  pll_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_q, retry_d;
  logic [7:0]       loss_q, loss_d;
  logic             pll_rst_q, pll_rst_d;
  logic             sys_rst_q, sys_rst_d;
  logic             ready_q, ready_d;
  logic             fail_q, fail_d;
  logic             lk;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lk)
  );

  // Next-state, counters and registered-output values
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    case (state_q)
      ST_PLL_RST: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        cnt_d = cnt_q + 1'b1;
        // lock seen on the timeout cycle still counts as lock
        if (lk) begin
          state_d = ST_STABLE;
        end else if (cnt_q == TO_LAST) begin
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 4'd1;
            state_d = ST_PLL_RST;
          end else begin
            state_d = ST_FAILED;
          end
        end
      end
      ST_STABLE: begin
        cnt_d = cnt_q + 1'b1;
        // a dropout restarts the lock wait without consuming a retry
        if (!lk) begin
          state_d = ST_WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_RUN;
          retry_d = 4'd0;
        end
      end
      ST_RUN: begin
        if (!lk) begin
          state_d = ST_PLL_RST;
          retry_d = 4'd0;
          if (loss_q != LOSS_CNT_MAX) loss_d = loss_q + 8'd1;
        end
      end
      ST_FAILED: begin
        state_d = ST_FAILED;
      end
      default: begin
        state_d = ST_PLL_RST;
      end
    endcase
    // counter restarts from zero in every newly entered state
    if (state_d != state_q) cnt_d = '0;

    pll_rst_d = (state_d == ST_PLL_RST) || (state_d == ST_FAILED);
    sys_rst_d = (state_d != ST_RUN);
    ready_d   = (state_d == ST_RUN);
    fail_d    = (state_d == ST_FAILED);
  end

  // State, counters and outputs, with rst overriding everything
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q   <= ST_PLL_RST;
      cnt_q     <= '0;
      retry_q   <= 4'd0;
      loss_q    <= 8'd0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      loss_q    <= loss_d;
      pll_rst_q <= pll_rst_d;
      sys_rst_q <= sys_rst_d;
      ready_q   <= ready_d;
      fail_q    <= fail_d;
    end
  end

  assign pll_rst   = pll_rst_q;
  assign sys_rst   = sys_rst_q;
  assign ready     = ready_q;
  assign fail      = fail_q;
  assign retry_cnt = retry_q;
  assign loss_cnt  = loss_q;
  assign state_o   = state_q;

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
- Controls the reset input of the on-chip general PLL (50 MHz refclk, 25/50/100/200 MHz outputs) and consumes its locked output.
- Pulses PLL reset, waits for lock with timeout and bounded retries, qualifies lock stability, then releases the system reset.
- Re-runs the sequence when lock is lost.
- Sits in the refclk domain, between the board reset and every PLL-clocked domain's reset synchroniser.

Parameters:
- RST_PULSE_CYCLES, 16: refclk cycles pll_rst is held high per attempt (min 1).
- LOCK_TIMEOUT_CYCLES, 50000: cycles to wait for synced lock before an attempt fails (1 ms at 50 MHz).
- LOCK_STABLE_CYCLES, 1024: consecutive synced-lock cycles required before release.
- MAX_RETRIES, 3: failed attempts allowed before the FAILED state; 0 means one attempt only.
- CNT_W, 16: width of the shared cycle counter; must hold the largest of the three cycle parameters.

Ports:
- refclk, in, 1: single clock; all logic is on this edge.
- rst, in, 1: synchronous, active-high reset.
- pll_locked, in, 1: PLL locked, asynchronous to refclk.
- pll_rst, out, 1: drives the PLL reset.
- sys_rst, out, 1: active-high reset to downstream domains.
- ready, out, 1: high only in RUN.
- fail, out, 1: sticky, high in FAILED.
- retry_cnt, out, 4: failed attempts in the current sequence.
- loss_cnt, out, 8: lock-loss events since rst; saturates at 255.
- state_o, out, 3: encoded current state, for debug.

Behaviour:
- Sync: pll_locked passes through a 2-FF synchroniser to give lk. All decisions use lk, so there is 2 cycles of added latency.
- Reset values (rst=1 at an edge), taking effect the next cycle:
  - state = PLL_RST; pll_rst=1; sys_rst=1; ready=0; fail=0.
  - retry_cnt=0; loss_cnt=0; counter=0; sync FFs=0.
- Reset mid-operation restarts from PLL_RST in any state and clears fail. The rst has priority over every transition.
- State encodings: PLL_RST=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAILED=4.
- PLL_RST: pll_rst=1, sys_rst=1. The counter runs from 0 to RST_PULSE_CYCLES-1, then the block goes to WAIT_LOCK with counter=0. pll_rst is therefore high for exactly RST_PULSE_CYCLES cycles.
- WAIT_LOCK: pll_rst=0, sys_rst=1.
  - If lk=1: go to STABLE, counter=0.
  - Else if counter == LOCK_TIMEOUT_CYCLES-1, the attempt fails:
    - retry_cnt < MAX_RETRIES: retry_cnt++ and go to PLL_RST.
    - Otherwise: go to FAILED.
  - lk=1 on the timeout cycle counts as lock; lock wins.
- STABLE: pll_rst=0, sys_rst=1.
  - If lk=0: go back to WAIT_LOCK, counter=0. The timeout restarts and this is not counted as a retry.
  - When counter reaches LOCK_STABLE_CYCLES-1 with lk=1: go to RUN and clear retry_cnt.
- RUN: sys_rst=0, ready=1. First RUN cycle is RST_PULSE_CYCLES + (cycles to lk) + LOCK_STABLE_CYCLES after PLL_RST entry.
  - lk=0 for one cycle means lock lost.
  - In that same edge: sys_rst=1 and ready=0 for the next cycle, loss_cnt++ (saturating), retry_cnt=0, go to PLL_RST.
- FAILED: pll_rst=1, sys_rst=1, fail=1. Terminal until rst.
- Outputs are registered. Transitions use the registered state with no combinational path from pll_locked to any output.
- Counter width is CNT_W and it never wraps. It is cleared on every state change.

Decomposition:
- Shared package pll_sup_pkg:
  - State enum/localparams (PLL_RST..FAILED, 3-bit).
  - Default timing constants derived from the 50 MHz refclk.
- One natural sub-module: sync_2ff, a generic 2-flop synchroniser with WIDTH=1 and reset value 0, reused by other domains.

Test Plan:
1. Normal bring-up: rst high 4 cycles, pll_locked rises 100 cycles after pll_rst falls, defaults used.
   - pll_rst is high exactly 16 cycles.
   - ready=1 and sys_rst=0 at cycle 16+100+2+1024 (±1 per sync edge alignment).
   - retry_cnt=0, loss_cnt=0.
2. Timeout/retry, with LOCK_TIMEOUT_CYCLES=100, MAX_RETRIES=2 and pll_locked held 0.
   - Three pll_rst pulses occur, with retry_cnt 0→1→2.
   - Then fail=1, state_o=4, pll_rst=1 permanently.
   - Asserting rst clears fail and restarts.
3. Glitch during STABLE: pll_locked drops for 1 cycle at stable count 500.
   - State returns to WAIT_LOCK and then STABLE again.
   - ready is delayed by the full 1024 after relock.
   - retry_cnt unchanged, loss_cnt=0.
4. Lock loss in RUN: drop pll_locked once.
   - sys_rst=1 and ready=0 within 3 cycles (2 sync + 1).
   - loss_cnt=1, a new 16-cycle pll_rst pulse, then ready again after relock.
5. Saturation/boundary:
   - Force 260 lock-loss cycles: loss_cnt stops at 255.
   - Lock arriving exactly on the timeout cycle goes to STABLE with no retry increment.
6. Reset mid-operation: assert rst during STABLE and during RUN.
   - On the next cycle: state_o=0, pll_rst=1, sys_rst=1, ready=0, all counters 0.
